// File: rtl/instruction_fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_e : fetch controller states (BOOT, RUN, HALTED)
//   ADDR_W_DEF    : default PC width in words
//   HALT_WORD_DEF : default encoding that stops fetch when halting is built in
//   NOP_WORD      : value of an empty IF/ID instruction slot
//   sat_inc32()   : saturating 32-bit increment used by the delivery counter
package fetch_pkg;

  localparam int          ADDR_W_DEF    = 5;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD      = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: read port of the instruction memory.
//   imem_addr : word address, driven by the fetch stage
//   imem_data : instruction word, returned combinationally by the memory
// Modports: master = fetch stage, slave = memory.
interface instruction_fetch_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_data;

  modport master (output imem_addr, input  imem_data);
  modport slave  (input  imem_addr, output imem_data);

endinterface

// File: rtl/instruction_fetch_pc_gen.sv
// fetch_pc_gen: program counter register.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   load       : take load_pc (branch redirect), wins over advance
//   load_pc    : redirect target, already truncated to ADDR_W bits
//   advance    : step to the next word, wrapping modulo 2^ADDR_W
//   pc         : current word address
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              advance,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] RESET_VAL = ADDR_W'(RESET_PC);

  // Wrap at 2^ADDR_W falls out of the fixed register width.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_VAL;
    end else if (load) begin
      pc <= load_pc;
    end else if (advance) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: first pipeline stage. Owns the PC, reads the instruction
// memory and fills the IF/ID register.
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   imem            : instruction memory read port (master side)
//   stall           : hold PC and IF/ID contents
//   redirect        : taken branch/jump, load PC from redirect_pc[ADDR_W-1:0]
//   if_id_instr/pc  : captured instruction and its word address
//   if_id_valid     : 0 marks a bubble
//   fetch_count     : saturating count of words delivered with valid=1
//   halted          : fetch stopped on HALT_WORD
// Build option: define FETCH_HALT_EN to stop fetching after HALT_WORD is
// delivered; without it halted is tied low and HALT_WORD is an ordinary word.
//
// state   | meaning
// --------+-----------------------------------------------------------
// BOOT    | one settle cycle after reset, nothing captured
// RUN     | normal fetch; redirect > stall > capture
// HALTED  | HALT_WORD delivered; PC frozen, bubbles only, left by reset
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int          ADDR_W    = ADDR_W_DEF,
  parameter int unsigned RESET_PC  = 0,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  instruction_fetch_if.master        imem,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic [31:0]                if_id_instr,
  output logic [31:0]                if_id_pc,
  output logic                       if_id_valid,
  output logic [31:0]                fetch_count,
  output logic                       halted
);

  localparam int PAD_W = 32 - ADDR_W;

  fetch_state_e      state_q, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              pc_load, pc_advance;
  logic [31:0]       instr_q, instr_nxt;
  logic [ADDR_W-1:0] cap_pc_q, cap_pc_nxt;
  logic              valid_q, valid_nxt;
  logic [31:0]       count_q, count_nxt;

  fetch_pc_gen #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (pc_load),
    .load_pc (redirect_pc[ADDR_W-1:0]),
    .advance (pc_advance),
    .pc      (pc)
  );

  // The register only holds RESET_PC after the first reset edge, so the
  // address is forced while reset is asserted.
  assign imem.imem_addr = reset ? 32'(RESET_PC) : {{PAD_W{1'b0}}, pc};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_BOOT;
      instr_q  <= NOP_WORD;
      cap_pc_q <= '0;
      valid_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_nxt;
      instr_q  <= instr_nxt;
      cap_pc_q <= cap_pc_nxt;
      valid_q  <= valid_nxt;
      count_q  <= count_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    instr_nxt  = instr_q;
    cap_pc_nxt = cap_pc_q;
    valid_nxt  = valid_q;
    count_nxt  = count_q;
    pc_load    = 1'b0;
    pc_advance = 1'b0;

    case (state_q)
      ST_BOOT: begin
        valid_nxt = 1'b0;
        state_nxt = ST_RUN;
      end

      ST_RUN: begin
        if (redirect) begin
          // Squash the word on the bus; old IF/ID payload stays visible.
          pc_load   = 1'b1;
          valid_nxt = 1'b0;
        end else if (!stall) begin
          instr_nxt  = imem.imem_data;
          cap_pc_nxt = pc;
          valid_nxt  = 1'b1;
          pc_advance = 1'b1;
          count_nxt  = sat_inc32(count_q);
`ifdef FETCH_HALT_EN
          // The halt word itself is delivered and counted.
          if (imem.imem_data == HALT_WORD) begin
            state_nxt = ST_HALTED;
          end
`endif
        end
      end

`ifdef FETCH_HALT_EN
      ST_HALTED: begin
        valid_nxt = 1'b0;
      end
`endif

      default: begin
        state_nxt = ST_BOOT;
        valid_nxt = 1'b0;
      end
    endcase
  end

  assign if_id_instr = instr_q;
  assign if_id_pc    = {{PAD_W{1'b0}}, cap_pc_q};
  assign if_id_valid = valid_q;
  assign fetch_count = count_q;

`ifdef FETCH_HALT_EN
  assign halted = (state_q == ST_HALTED);

  logic unused_redirect_hi;
  assign unused_redirect_hi = ^redirect_pc[31:ADDR_W];
`else
  assign halted = 1'b0;

  logic unused_redirect_hi;
  assign unused_redirect_hi = ^{redirect_pc[31:ADDR_W], HALT_WORD};
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  import fetch_pkg::*;

  localparam int          AW       = 5;
  localparam int          DEPTH    = 1 << AW;
  localparam int unsigned RST_PC   = 0;
  localparam logic [31:0] HALT_W   = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] if_id_instr, if_id_pc, fetch_count;
  logic        if_id_valid, halted;
  logic [31:0] mem [DEPTH];

  instruction_fetch_if imem_bus ();
  assign imem_bus.imem_data = mem[imem_bus.imem_addr[AW-1:0]];

  instruction_fetch #(
    .ADDR_W    (AW),
    .RESET_PC  (RST_PC),
    .HALT_WORD (HALT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem_bus),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid),
    .fetch_count (fetch_count),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (stage behaviour as a few rules) -------
  bit          m_boot, m_halt, m_valid;
  int unsigned m_pc, m_ifpc;
  logic [31:0] m_instr, m_cnt;

  task automatic model_reset();
    m_boot = 1; m_halt = 0; m_valid = 0;
    m_pc = RST_PC % DEPTH; m_ifpc = 0; m_instr = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit rst, input bit st, input bit rd, input logic [31:0] rpc);
    if (rst) begin
      model_reset();
    end else if (m_boot) begin
      m_boot = 0; m_valid = 0;
    end else if (m_halt) begin
      m_valid = 0;
    end else if (rd) begin
      m_pc = rpc % DEPTH; m_valid = 0;
    end else if (!st) begin
      m_instr = mem[m_pc];
      m_ifpc  = m_pc;
      m_valid = 1;
      m_pc    = (m_pc + 1) % DEPTH;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`ifdef FETCH_HALT_EN
      if (m_instr == HALT_W) m_halt = 1;
`endif
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".addr"},   imem_bus.imem_addr, reset ? 32'(RST_PC) : 32'(m_pc));
    check({tag, ".valid"},  32'(if_id_valid), 32'(m_valid));
    check({tag, ".instr"},  if_id_instr, m_instr);
    check({tag, ".pc"},     if_id_pc, 32'(m_ifpc));
    check({tag, ".count"},  fetch_count, m_cnt);
    check({tag, ".halted"}, 32'(halted), 32'(m_halt));
  endtask

  // ---------------- directed vector table ----------------------------------
  typedef struct {
    bit          stall;
    bit          redirect;
    logic [31:0] rpc;
    bit          exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic [31:0] exp_addr;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic step(input bit rst, input bit st, input bit rd, input logic [31:0] rpc);
    @(negedge clk);
    reset = rst; stall = st; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mword(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = mword(i);

    //            st rd rpc            v  instr        ifpc   cnt addr
    vecs[0]  = '{0, 0, 32'd0,          0, 32'h0,       32'd0,  0, 0};   // BOOT
    vecs[1]  = '{0, 0, 32'd0,          1, mword(0),    32'd0,  1, 1};
    vecs[2]  = '{0, 0, 32'd0,          1, mword(1),    32'd1,  2, 2};
    vecs[3]  = '{1, 0, 32'd0,          1, mword(1),    32'd1,  2, 2};   // stall x3
    vecs[4]  = '{1, 0, 32'd0,          1, mword(1),    32'd1,  2, 2};
    vecs[5]  = '{1, 0, 32'd0,          1, mword(1),    32'd1,  2, 2};
    vecs[6]  = '{0, 0, 32'd0,          1, mword(2),    32'd2,  3, 3};
    vecs[7]  = '{1, 1, 32'd7,          0, mword(2),    32'd2,  3, 7};   // redirect beats stall
    vecs[8]  = '{0, 0, 32'd0,          1, mword(7),    32'd7,  4, 8};
    vecs[9]  = '{0, 1, 32'd31,         0, mword(7),    32'd7,  4, 31};
    vecs[10] = '{0, 0, 32'd0,          1, mword(31),   32'd31, 5, 0};   // wrap
    vecs[11] = '{0, 0, 32'd0,          1, mword(0),    32'd0,  6, 1};
    vecs[12] = '{0, 1, 32'hFFFF_FFE3,  0, mword(0),    32'd0,  6, 3};   // upper bits dropped
    vecs[13] = '{0, 0, 32'd0,          1, mword(3),    32'd3,  7, 4};

    // Reset: address held at RESET_PC, outputs cleared.
    #1;
    check("rst.addr_pre", imem_bus.imem_addr, 32'(RST_PC));
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst.addr",   imem_bus.imem_addr, 32'(RST_PC));
    check("rst.valid",  32'(if_id_valid), 32'd0);
    check("rst.instr",  if_id_instr, 32'd0);
    check("rst.pc",     if_id_pc, 32'd0);
    check("rst.count",  fetch_count, 32'd0);
    check("rst.halted", 32'(halted), 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      step(0, vecs[i].stall, vecs[i].redirect, vecs[i].rpc);
      check($sformatf("vec%0d.valid", i),  32'(if_id_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d.instr", i),  if_id_instr, vecs[i].exp_instr);
      check($sformatf("vec%0d.pc", i),     if_id_pc, vecs[i].exp_pc);
      check($sformatf("vec%0d.count", i),  fetch_count, vecs[i].exp_cnt);
      check($sformatf("vec%0d.addr", i),   imem_bus.imem_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d.halted", i), 32'(halted), 32'd0);
    end

    // Reset in the middle of RUN discards everything on one edge.
    @(negedge clk);
    reset = 1; stall = 0; redirect = 0;
    #1;
    check("midrst.addr_comb", imem_bus.imem_addr, 32'(RST_PC));
    @(posedge clk); #1;
    check("midrst.valid", 32'(if_id_valid), 32'd0);
    check("midrst.instr", if_id_instr, 32'd0);
    check("midrst.pc",    if_id_pc, 32'd0);
    check("midrst.count", fetch_count, 32'd0);
    step(0, 0, 0, 0);
    check("midrst.boot_valid", 32'(if_id_valid), 32'd0);
    check("midrst.boot_addr",  imem_bus.imem_addr, 32'(RST_PC));
    step(0, 0, 0, 0);
    check("midrst.first_valid", 32'(if_id_valid), 32'd1);
    check("midrst.first_instr", if_id_instr, mword(0));
    check("midrst.first_count", fetch_count, 32'd1);

    // Halt word at address 2.
    mem[2] = HALT_W;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("halt.deliver_valid", 32'(if_id_valid), 32'd1);
    check("halt.deliver_instr", if_id_instr, HALT_W);
    check("halt.deliver_count", fetch_count, 32'd3);
`ifdef FETCH_HALT_EN
    check("halt.halted_rise", 32'(halted), 32'd1);
    step(0, 0, 0, 0);
    check("halt.after_valid", 32'(if_id_valid), 32'd0);
    check("halt.after_addr",  imem_bus.imem_addr, 32'd3);
    check("halt.after_count", fetch_count, 32'd3);
    step(0, 0, 1, 32'd9);
    check("halt.redir_addr",   imem_bus.imem_addr, 32'd3);
    check("halt.redir_valid",  32'(if_id_valid), 32'd0);
    check("halt.redir_halted", 32'(halted), 32'd1);
    check("halt.redir_instr",  if_id_instr, HALT_W);
`else
    check("halt.halted_low", 32'(halted), 32'd0);
    step(0, 0, 0, 0);
    check("halt.cont_valid", 32'(if_id_valid), 32'd1);
    check("halt.cont_instr", if_id_instr, mword(3));
    check("halt.cont_pc",    if_id_pc, 32'd3);
    check("halt.cont_count", fetch_count, 32'd4);
    step(0, 0, 1, 32'd9);
    check("halt.redir_addr", imem_bus.imem_addr, 32'd9);
`endif

    // Randomized run against the reference model.
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      if ($urandom_range(0, 15) == 0) mem[i] = HALT_W;
    end
    step(1, 0, 0, 0);
    model_reset();
    check_model("rnd.reset");
    for (int c = 0; c < 600; c++) begin
      bit          r, s, d;
      logic [31:0] t;
      r = ($urandom_range(0, 59) == 0);
      s = ($urandom_range(0, 9) < 3);
      d = ($urandom_range(0, 9) < 2);
      t = $urandom;
      step(r, s, d, t);
      model_edge(r, s, d, t);
      check_model($sformatf("rnd%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage: owns the program counter, drives the word address into the instruction memory, captures the returned 32-bit instruction word into the IF/ID pipeline register, and handles stall, branch redirect and optional halt. It is the initiator for the instruction memory's read port and the first stage of the RISC pipeline.

## Interface
- ADDR_W, 5, PC width in words; the memory holds 2^ADDR_W words.
- RESET_PC, 0, word address fetched first after reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch (used only with FETCH_HALT_EN).

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- imem_addr  out  32  word address to instruction memory; {zeros, pc}
- imem_data  in  32  instruction word; memory read is combinational, valid in the same cycle
- stall  in  1  hold PC and IF/ID contents
- redirect  in  1  branch/jump taken; load PC from redirect_pc
- redirect_pc  in  32  target word address; only bits [ADDR_W-1:0] used
- if_id_instr  out  32  captured instruction
- if_id_pc  out  32  word address of if_id_instr, zero-extended
- if_id_valid  out  1  if_id_instr is a real instruction (0 = bubble)
- fetch_count  out  32  number of instructions delivered with valid=1, saturating
- halted  out  1  fetch stopped on HALT_WORD

## Operation
- States: BOOT, RUN, HALTED.
- reset=1: state=BOOT, pc=RESET_PC, if_id_instr=0, if_id_pc=0, if_id_valid=0, fetch_count=0, halted=0. imem_addr=RESET_PC throughout reset. Reset mid-operation discards everything in the same edge.
- BOOT: one settle cycle; no capture, pc held, if_id_valid=0; next state RUN.
- RUN, priority redirect > stall > normal:
  - redirect=1: pc<=redirect_pc[ADDR_W-1:0]; if_id_valid<=0 (squash); if_id_instr/if_id_pc keep old values; count unchanged. Overrides stall.
  - stall=1: pc, if_id_*, fetch_count all held.
  - otherwise: if_id_instr<=imem_data, if_id_pc<=pc, if_id_valid<=1, pc<=pc+1, fetch_count<=fetch_count+1 (saturates at 32'hFFFF_FFFF).
- PC arithmetic modulo 2^ADDR_W: pc=2^ADDR_W-1 increments to 0.
- HALTED (FETCH_HALT_EN only): pc frozen, if_id_valid<=0, halted=1; stall and redirect ignored; exit only by reset.

## Timing
- Address-to-capture latency: 1 cycle; instruction at pc appears on if_id_* on the next rising edge.
- First valid instruction: the second rising edge after reset deasserts (BOOT, then capture).
- Redirect: one bubble cycle; target instruction valid two edges after redirect is sampled.
- Stall asserted N cycles: IF/ID held N cycles, no duplication or loss.
- halted rises on the same edge that delivers HALT_WORD with if_id_valid=1; if_id_valid=0 from the following edge.

## Configuration
- FETCH_HALT_EN defined: in normal RUN capture, imem_data==HALT_WORD moves state to HALTED after delivering that word (counted).
- Not defined: HALTED state absent, halted tied 0, HALT_WORD fetched as an ordinary instruction.

## Structure
- fetch_pkg: state enum (BOOT, RUN, HALTED), HALT_WORD default, NOP_WORD=32'h0, ADDR_W default.
- One sub-module: fetch_pc_gen (PC register, increment/wrap, redirect mux); top holds FSM, IF/ID register, counter.

## Test plan
- Reset, memory words 0..2 = A,B,C, no stall -> imem_addr 0,0,1,2; if_id_instr A,B,C with if_id_pc 0,1,2 from the second post-reset edge; fetch_count=3.
- stall high 3 cycles after B captured -> if_id_instr=B, if_id_pc=1, pc=2 held; then C delivered once.
- redirect with redirect_pc=7 during stall -> next edge valid=0, pc=7; following edge if_id_pc=7, count +1 only.
- pc=31 (ADDR_W=5), no stall -> next imem_addr=0, if_id_pc=31 then 0.
- FETCH_HALT_EN, word 2 = 32'hFFFF_FFFF -> delivered with valid=1, halted=1, then valid=0, pc frozen, redirect ignored; without macro fetch continues to word 3.
- reset asserted mid-RUN with fetch_count=5 -> next edge all outputs zero, pc=RESET_PC, state BOOT.
